trace_injector: RTL and testbench

Trace-driven packet injector for the ring NoC testbench. It sits directly downstream of the trace memory reader. It drives the reader's entry index (`ctr`) and consumes the returned `src`/`dest`/`cycle` fields. It holds each entry until a free-running simulation timestamp reaches the entry's scheduled cycle, then presents the packet to the ring's injection port over a valid/ready handshake, one entry at a time.

---
 rtl/noc_trace_pkg.sv | 19 +
 rtl/trace_injector_sat_counter.sv | 14 +
 rtl/trace_injector.sv | 136 +++++++++++++
 tb/tb_trace_injector.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_trace_pkg.sv
// noc_trace_pkg: shared trace-injector types, trace constants and entry field offsets
package noc_trace_pkg;
  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_FETCH = 5'b00010,
    S_HOLD  = 5'b00100,
    S_SEND  = 5'b01000,
    S_DONE  = 5'b10000
  } state_e;
  localparam int unsigned NODE_BITS = 4;
  localparam logic [31:0] END_MARK = 32'hFFFF_FFFF;
  localparam int unsigned LAST_ENTRY = 65535;
  localparam int unsigned SRC_HI = 39;
  localparam int unsigned SRC_LO = 36;
  localparam int unsigned DEST_HI = 35;
  localparam int unsigned DEST_LO = 32;
  localparam int unsigned CYCLE_HI = 31;
  localparam int unsigned CYCLE_LO = 0;
endpackage

// File: rtl/trace_injector_sat_counter.sv
// sat_counter: saturating up-counter (clk, rst, inc, clr in; q out)
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    q <= (rst || clr) ? '0 : (inc && q != '1) ? q + WIDTH'(1) : q;
  end
endmodule

// File: rtl/trace_injector.sv
// trace_injector: fetches trace entries via ctr, holds each until now reaches its cycle, offers it on pkt_valid/pkt_ready; reports now, pkt/late/skip/stall counts and done
module trace_injector
  import noc_trace_pkg::*;
#(
  parameter int unsigned NODE_BITS  = noc_trace_pkg::NODE_BITS,
  parameter int unsigned LAST_ENTRY = noc_trace_pkg::LAST_ENTRY,
  parameter logic [31:0] END_MARK   = noc_trace_pkg::END_MARK,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [31:0]          ctr,
  input  logic [15:0]          src_in,
  input  logic [15:0]          dest_in,
  input  logic [31:0]          cycle_in,
  output logic                 pkt_valid,
  input  logic                 pkt_ready,
  output logic [NODE_BITS-1:0] pkt_src,
  output logic [NODE_BITS-1:0] pkt_dest,
  output logic [31:0]          pkt_time,
  output logic [31:0]          now,
  output logic [31:0]          pkt_cnt,
  output logic [15:0]          late_cnt,
  output logic [15:0]          skip_cnt,
  output logic [31:0]          stall_cnt,
  output logic                 done
);
  localparam int unsigned WW = RD_LAT < 1 ? 1 : $clog2(RD_LAT + 1);
  localparam logic [WW-1:0] RELOAD = WW'(RD_LAT);
  localparam logic [31:0] LAST = 32'(LAST_ENTRY);
  state_e state_q, state_d;
  logic [31:0] ctr_q, ctr_d, now_q, now_d, pkt_time_q, pkt_time_d, pkt_cnt_q, pkt_cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [NODE_BITS-1:0] pkt_src_q, pkt_src_d, pkt_dest_q, pkt_dest_d;
  logic pkt_valid_q, pkt_valid_d;
  logic last, fire, active, late_inc, skip_inc, unused_bits;
  assign last = ctr_q == LAST;
  assign fire = pkt_valid_q && pkt_ready;
  assign active = state_q inside {S_FETCH, S_HOLD, S_SEND};
  assign unused_bits = ^{src_in, dest_in};
  always_comb begin
    state_d = state_q;
    ctr_d = ctr_q;
    wait_d = wait_q;
    pkt_valid_d = pkt_valid_q;
    pkt_src_d = pkt_src_q;
    pkt_dest_d = pkt_dest_q;
    pkt_time_d = pkt_time_q;
    late_inc = 1'b0;
    skip_inc = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ctr_d = 32'd1;
          wait_d = RELOAD;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WW'(1);
        end else if (cycle_in == END_MARK) begin
          state_d = S_DONE;
        end else if (src_in[NODE_BITS-1:0] == dest_in[NODE_BITS-1:0]) begin
          skip_inc = 1'b1;
          state_d = last ? S_DONE : S_FETCH;
          ctr_d = last ? ctr_q : ctr_q + 32'd1;
          wait_d = RELOAD;
        end else begin
          pkt_src_d = src_in[NODE_BITS-1:0];
          pkt_dest_d = dest_in[NODE_BITS-1:0];
          pkt_time_d = cycle_in;
          late_inc = now_q > cycle_in;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (now_q >= pkt_time_q) begin
          pkt_valid_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (fire) begin
          pkt_valid_d = 1'b0;
          state_d = last ? S_DONE : S_FETCH;
          ctr_d = last ? ctr_q : ctr_q + 32'd1;
          wait_d = RELOAD;
        end
      end
      S_DONE: pkt_valid_d = 1'b0;
      default: begin
        state_d = S_IDLE;
        ctr_d = '0;
        pkt_valid_d = 1'b0;
      end
    endcase
  end
  assign now_d = (state_q == S_IDLE) ? '0 : (active && now_q != '1) ? now_q + 32'd1 : now_q;
  assign pkt_cnt_d = fire ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ctr_q <= '0;
      wait_q <= '0;
      now_q <= '0;
      pkt_valid_q <= 1'b0;
      pkt_src_q <= '0;
      pkt_dest_q <= '0;
      pkt_time_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q <= ctr_d;
      wait_q <= wait_d;
      now_q <= now_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_src_q <= pkt_src_d;
      pkt_dest_q <= pkt_dest_d;
      pkt_time_q <= pkt_time_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
  sat_counter #(.WIDTH(16)) u_late (.clk(clk), .rst(rst), .inc(late_inc), .clr(1'b0), .q(late_cnt));
  sat_counter #(.WIDTH(16)) u_skip (.clk(clk), .rst(rst), .inc(skip_inc), .clr(1'b0), .q(skip_cnt));
  sat_counter #(.WIDTH(32)) u_stall (.clk(clk), .rst(rst), .inc(pkt_valid_q && !pkt_ready), .clr(1'b0), .q(stall_cnt));
  assign ctr = ctr_q;
  assign now = now_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_src = pkt_src_q;
  assign pkt_dest = pkt_dest_q;
  assign pkt_time = pkt_time_q;
  assign pkt_cnt = pkt_cnt_q;
  assign done = state_q == S_DONE;
endmodule

// File: tb/tb_trace_injector.sv
// tb_trace_injector: directed and randomized checks of trace_injector against a schedule-level model
module tb_trace_injector;
  localparam int LAST = 40;
  localparam int RDL = 2;
  localparam int NR = 4096;
  localparam int MAXC = 4000;
  localparam logic [31:0] ENDM = 32'hFFFF_FFFF;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pkt_ready = 1'b0;
  logic [31:0] ctr, cycle_in, pkt_time, now, pkt_cnt, stall_cnt;
  logic [15:0] src_in, dest_in, late_cnt, skip_cnt;
  logic [3:0] pkt_src, pkt_dest;
  logic pkt_valid, done;
  logic [15:0] m_src [0:LAST];
  logic [15:0] m_dest [0:LAST];
  logic [31:0] m_cyc [0:LAST];
  logic [5:0] c1 = '0, c2 = '0;
  bit rdy [NR];
  int checks = 0, errors = 0;
  typedef struct {
    logic [3:0] s;
    logic [3:0] d;
    logic [31:0] t;
    int rise;
    int acc;
  } pkt_t;
  pkt_t ep[$];
  int ec[$];
  int e_late, e_skip, e_stall, e_now, e_ctr;

  trace_injector #(.LAST_ENTRY(LAST), .RD_LAT(RDL)) dut (
    .clk(clk), .rst(rst), .start(start), .ctr(ctr),
    .src_in(src_in), .dest_in(dest_in), .cycle_in(cycle_in),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_src(pkt_src), .pkt_dest(pkt_dest), .pkt_time(pkt_time),
    .now(now), .pkt_cnt(pkt_cnt), .late_cnt(late_cnt), .skip_cnt(skip_cnt),
    .stall_cnt(stall_cnt), .done(done)
  );

  always #5 clk = ~clk;

  // two-edge read latency reader model
  always @(posedge clk) begin
    c1 <= ctr[5:0];
    c2 <= c1;
  end
  assign src_in = m_src[c2];
  assign dest_in = m_dest[c2];
  assign cycle_in = m_cyc[c2];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_trace();
    for (int i = 0; i <= LAST; i++) begin
      m_src[i] = '0;
      m_dest[i] = '0;
      m_cyc[i] = ENDM;
    end
  endtask

  task automatic set_e(int i, logic [3:0] s, logic [3:0] d, logic [31:0] c);
    m_src[i] = {12'($urandom), s};
    m_dest[i] = {12'($urandom), d};
    m_cyc[i] = c;
  endtask

  task automatic fill_rdy(int pct);
    for (int i = 0; i < NR; i++) rdy[i] = $urandom_range(0, 99) < pct;
    rdy[NR-1] = 1'b1;
  endtask

  task automatic rand_trace(bit with_end);
    logic [3:0] s;
    int base;
    base = 0;
    clear_trace();
    for (int i = 1; i <= LAST; i++) begin
      s = 4'($urandom);
      base += $urandom_range(0, 9);
      set_e(i, s, ($urandom_range(0, 3) == 0) ? s : 4'($urandom), base);
    end
    if (with_end) m_cyc[$urandom_range(4, LAST)] = ENDM;
  endtask

  // schedule model: capture happens RD_LAT cycles into a fetch, the offer waits for max(cycle, capture+1),
  // acceptance is the first ready cycle after the offer; timestamps are counted from the start edge
  task automatic build_model();
    int t, idx, cap, r, s, cy;
    pkt_t p;
    ep.delete();
    ec.delete();
    e_late = 0;
    e_skip = 0;
    e_stall = 0;
    t = 0;
    idx = 1;
    forever begin
      ec.push_back(idx);
      cap = t + RDL;
      e_now = cap + 1;
      if (m_cyc[idx] == ENDM) break;
      cy = int'(m_cyc[idx]);
      if (m_src[idx][3:0] == m_dest[idx][3:0]) begin
        e_skip++;
      end else begin
        if (cap > cy) e_late++;
        r = (cy > cap + 1) ? cy : cap + 1;
        s = r + 1;
        while (s < NR - 1 && !rdy[s]) s++;
        e_stall += s - r - 1;
        p.s = m_src[idx][3:0];
        p.d = m_dest[idx][3:0];
        p.t = m_cyc[idx];
        p.rise = r + 1;
        p.acc = s;
        ep.push_back(p);
        e_now = s + 1;
      end
      if (idx == LAST) break;
      idx++;
      t = e_now;
    end
    e_ctr = idx;
  endtask

  task automatic check_reset(string tag);
    chk({tag, " ctr"}, ctr, 0);
    chk({tag, " pkt_valid"}, pkt_valid, 0);
    chk({tag, " pkt_src"}, pkt_src, 0);
    chk({tag, " pkt_dest"}, pkt_dest, 0);
    chk({tag, " pkt_time"}, pkt_time, 0);
    chk({tag, " now"}, now, 0);
    chk({tag, " pkt_cnt"}, pkt_cnt, 0);
    chk({tag, " late_cnt"}, late_cnt, 0);
    chk({tag, " skip_cnt"}, skip_cnt, 0);
    chk({tag, " stall_cnt"}, stall_cnt, 0);
    chk({tag, " done"}, done, 0);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    start = 1'b0;
    pkt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset(tag);
  endtask

  task automatic run_trace(string tag);
    int k, pi, ci;
    logic pv;
    logic [31:0] lc;
    build_model();
    k = 0;
    pi = 0;
    ci = 0;
    pv = 1'b0;
    lc = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!done && k < MAXC) begin
      pkt_ready = rdy[k < NR ? k : NR - 1];
      @(negedge clk);
      if (ctr != lc) begin
        chk({tag, " ctr_seq"}, ctr, ci < ec.size() ? ec[ci] : 0);
        ci++;
        lc = ctr;
      end
      if (pkt_valid) begin
        if (pi < ep.size()) begin
          chk({tag, " pkt_fields"}, {pkt_src, pkt_dest, pkt_time}, {ep[pi].s, ep[pi].d, ep[pi].t});
          if (!pv) chk({tag, " offer_now"}, now, ep[pi].rise);
          if (pkt_ready) begin
            chk({tag, " accept_now"}, now, ep[pi].acc);
            pi++;
          end
        end else begin
          chk({tag, " extra_pkt"}, pi, ep.size());
        end
      end
      pv = pkt_valid;
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " valid_in_done"}, pkt_valid, 0);
    chk({tag, " ctr_final"}, ctr, e_ctr);
    chk({tag, " ctr_fetches"}, ci, ec.size());
    chk({tag, " pkts_seen"}, pi, ep.size());
    chk({tag, " now_final"}, now, e_now);
    chk({tag, " pkt_cnt"}, pkt_cnt, ep.size());
    chk({tag, " late_cnt"}, late_cnt, e_late);
    chk({tag, " skip_cnt"}, skip_cnt, e_skip);
    chk({tag, " stall_cnt"}, stall_cnt, e_stall);
  endtask

  initial begin
    do_reset("por");
    repeat (3) @(posedge clk);
    #1;
    chk("idle now", now, 0);
    chk("idle ctr", ctr, 0);

    clear_trace();
    set_e(1, 4'd1, 4'd3, 32'd10);
    set_e(2, 4'd2, 4'd5, 32'd20);
    fill_rdy(100);
    run_trace("basic");
    chk("basic pkt_cnt", pkt_cnt, 2);
    chk("basic ctr", ctr, 3);
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("done ignores start", {done, ctr, now}, {1'b1, 32'd3, 32'd25});

    do_reset("r_late");
    clear_trace();
    set_e(1, 4'd7, 4'd2, 32'd0);
    run_trace("late");
    chk("late late_cnt", late_cnt, 1);

    do_reset("r_skip");
    clear_trace();
    set_e(1, 4'd4, 4'd4, 32'd5);
    set_e(2, 4'd4, 4'd6, 32'd15);
    run_trace("skip");
    chk("skip skip_cnt", skip_cnt, 1);
    chk("skip pkt_cnt", pkt_cnt, 1);

    do_reset("r_stall");
    clear_trace();
    set_e(1, 4'd1, 4'd2, 32'd10);
    fill_rdy(100);
    for (int i = 11; i <= 17; i++) rdy[i] = 1'b0;
    run_trace("stall");
    chk("stall stall_cnt", stall_cnt, 7);

    do_reset("r_mid");
    clear_trace();
    set_e(1, 4'd5, 4'd6, 32'd8);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 100 && !pkt_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid valid_seen", pkt_valid, 1);
    rst = 1'b1;
    pkt_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pkt_ready = 1'b0;
    check_reset("mid_rst");
    fill_rdy(100);
    run_trace("after_rst");

    for (int r = 0; r < 2; r++) begin
      do_reset("r_rand");
      rand_trace(1'b1);
      fill_rdy(70);
      run_trace("rand");
    end

    do_reset("r_full");
    rand_trace(1'b0);
    fill_rdy(80);
    run_trace("full");
    chk("full ctr_last", ctr, LAST);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
